branch_resolution_unit: RTL and testbench
=========================================

# branch_resolution_unit

Tracks every fetched instruction's branch prediction (from the BTB lookup in fetch) in an in-order queue until execution resolves it, then compares prediction to outcome. Produces the BTB update bundle (`update_en`, `branch_taken`, `resolved_pc`, `resolved_target`, `resolved_state`) and the misprediction redirect/flush for fetch. Sits between the fetch stage, the branch predictor and the ID-stage branch comparator.

## Interface
- DEPTH, 4, queue entries (power of two, 2..16)
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- push_valid  in  1  fetch delivers one instruction's prediction
- push_ready  out  1  queue not full (count < DEPTH)
- push_pc  in  32  fetched PC
- push_pred_taken  in  1  predictor said taken
- push_pred_target  in  32  predicted next PC
- push_state  in  2  counter state read at fetch
- res_valid  in  1  oldest in-flight instruction resolved this cycle
- res_is_branch  in  1  resolved instruction is a conditional branch
- res_taken  in  1  actual direction
- res_target  in  32  computed branch target (valid whenever res_is_branch)
- update_en, branch_taken  out  1 each  BTB update strobe / actual direction
- resolved_pc, resolved_target  out  32 each  BTB update address / target
- resolved_state  out  2  counter state captured at fetch
- redirect_valid  out  1  mispredict; fetch restarts at redirect_pc
- redirect_pc  out  32  correct next PC
- res_error  out  1  res_valid arrived with queue empty (sticky until reset)
- branch_count, mispredict_count  out  32 each  saturating statistics

## Operation
- Entry = {pc, pred_taken, pred_target, state}, 67 bits; circular buffer, rd/wr pointers log2(DEPTH) bits plus count 0..DEPTH.
- Push accepted when push_valid && push_ready; pop when res_valid && count != 0.
- Mispredict evaluation on popped entry E:
  - branch, res_taken != E.pred_taken -> mispredict.
  - branch, both taken, res_target != E.pred_target -> mispredict.
  - non-branch, E.pred_taken = 1 -> mispredict (BTB alias).
- Correct PC: branch && res_taken ? res_target : E.pc + 4 (mod 2^32).
- Update bundle on popped branch: update_en=1, branch_taken=res_taken, resolved_pc=E.pc, resolved_target=res_target (taken or not), resolved_state=E.state. Non-branch pops: update_en=0.
- Mispredict: redirect_valid=1, redirect_pc=correct PC; all queue entries (younger wrong-path) discarded: count, rd, wr -> 0.
- Counters: branch_count += 1 per popped branch; mispredict_count += 1 per mispredict (any kind); both hold at 0xFFFF_FFFF.
- res_valid with empty queue: no pop, no outputs, res_error set.

## Timing
- Reset: queue empty, push_ready=1, all other outputs 0, counters 0.
- update_en, branch_taken, resolved_*, redirect_valid, redirect_pc registered: asserted exactly one cycle after the res_valid edge, for one cycle; otherwise 0 (data fields hold last value).
- Flush takes effect at the same edge that registers redirect_valid; count=0 in the following cycle.
- Simultaneous push and pop, no mispredict: both occur, count unchanged; allowed when full only if push_ready was 1 (push_ready purely from count, no pop bypass).
- Simultaneous push and mispredicting pop: push discarded (wrong path).
- Pointer wrap at DEPTH-1 -> 0; full at count==DEPTH, empty at 0.
- Reset asserted mid-operation: queue and all outputs cleared immediately, asynchronously.

## Test plan
- Push pc=0x100 pred NT state 00; resolve branch NT target 0x140 -> next cycle update_en=1, branch_taken=0, resolved_pc=0x100, resolved_target=0x140, redirect_valid=0, branch_count=1.
- Push pc=0x200 pred T target 0x300 state 10; resolve taken target 0x380 -> redirect_valid=1, redirect_pc=0x380, mispredict_count=1, count=0.
- Push 0x10,0x14,0x18; resolve 0x10 branch taken target 0x40 (pred NT) -> redirect_pc=0x40, 0x14/0x18 discarded; next res_valid -> res_error=1.
- Fill DEPTH=4 entries -> push_ready=0; pop+push same cycle blocked; pop alone -> push_ready=1; 10 push/pop rounds exercise pointer wrap with FIFO order preserved.
- Non-branch pc=0x500 pred T target 0x600, res_is_branch=0 -> update_en=0, redirect_valid=1, redirect_pc=0x504.
- Assert rst with 3 entries queued and redirect pending -> all outputs 0, push_ready=1 immediately, counters 0.

Source files
------------

// File: rtl/branch_resolution_unit_if.sv
// Fetch-side push, execute-side resolve, and BTB update / redirect bundle
// for the branch resolution unit.
interface branch_resolution_unit_if;
    logic        push_valid;
    logic        push_ready;
    logic [31:0] push_pc;
    logic        push_pred_taken;
    logic [31:0] push_pred_target;
    logic [1:0]  push_state;

    logic        res_valid;
    logic        res_is_branch;
    logic        res_taken;
    logic [31:0] res_target;

    logic        update_en;
    logic        branch_taken;
    logic [31:0] resolved_pc;
    logic [31:0] resolved_target;
    logic [1:0]  resolved_state;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        res_error;
    logic [31:0] branch_count;
    logic [31:0] mispredict_count;

    modport master (
        output push_valid, push_pc, push_pred_taken, push_pred_target, push_state,
        output res_valid, res_is_branch, res_taken, res_target,
        input  push_ready, update_en, branch_taken, resolved_pc, resolved_target,
        input  resolved_state, redirect_valid, redirect_pc, res_error,
        input  branch_count, mispredict_count
    );

    modport slave (
        input  push_valid, push_pc, push_pred_taken, push_pred_target, push_state,
        input  res_valid, res_is_branch, res_taken, res_target,
        output push_ready, update_en, branch_taken, resolved_pc, resolved_target,
        output resolved_state, redirect_valid, redirect_pc, res_error,
        output branch_count, mispredict_count
    );
endinterface

// File: rtl/branch_resolution_unit.sv
// In-order queue of fetch-time branch predictions; compares each against the
// resolved outcome, emits the BTB update bundle and mispredict redirect/flush.
module branch_resolution_unit #(
    parameter int unsigned DEPTH = 4
) (
    input logic                    clk,
    input logic                    rst,
    branch_resolution_unit_if.slave bru
);
    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    typedef struct packed {
        logic [31:0] pc;
        logic        pred_taken;
        logic [31:0] pred_target;
        logic [1:0]  state;
    } entry_t;

    entry_t             mem_q [DEPTH];
    entry_t             mem_d [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;

    logic               update_en_q, update_en_d;
    logic               branch_taken_q, branch_taken_d;
    logic [31:0]        resolved_pc_q, resolved_pc_d;
    logic [31:0]        resolved_target_q, resolved_target_d;
    logic [1:0]         resolved_state_q, resolved_state_d;
    logic               redirect_valid_q, redirect_valid_d;
    logic [31:0]        redirect_pc_q, redirect_pc_d;
    logic               res_error_q, res_error_d;
    logic [31:0]        branch_count_q, branch_count_d;
    logic [31:0]        mispredict_count_q, mispredict_count_d;

    entry_t      head;
    logic        push_ready;
    logic        push;
    logic        pop;
    logic        mispredict;
    logic [31:0] correct_pc;

    assign push_ready = (count_q != DEPTH_C);

    always_comb begin
        head = mem_q[rd_ptr_q];
        pop  = bru.res_valid && (count_q != '0);
        push = bru.push_valid && push_ready;

        // A non-branch predicted taken is a BTB alias and must be undone.
        mispredict = 1'b0;
        if (bru.res_is_branch) begin
            if (bru.res_taken != head.pred_taken)
                mispredict = 1'b1;
            else if (bru.res_taken && (bru.res_target != head.pred_target))
                mispredict = 1'b1;
        end else begin
            mispredict = head.pred_taken;
        end

        correct_pc = (bru.res_is_branch && bru.res_taken) ? bru.res_target
                                                          : head.pc + 32'd4;
    end

    always_comb begin
        mem_d              = mem_q;
        rd_ptr_d           = rd_ptr_q;
        wr_ptr_d           = wr_ptr_q;
        count_d            = count_q;
        update_en_d        = 1'b0;
        redirect_valid_d   = 1'b0;
        branch_taken_d     = branch_taken_q;
        resolved_pc_d      = resolved_pc_q;
        resolved_target_d  = resolved_target_q;
        resolved_state_d   = resolved_state_q;
        redirect_pc_d      = redirect_pc_q;
        res_error_d        = res_error_q | (bru.res_valid && (count_q == '0));
        branch_count_d     = branch_count_q;
        mispredict_count_d = mispredict_count_q;

        if (pop && bru.res_is_branch) begin
            update_en_d       = 1'b1;
            branch_taken_d    = bru.res_taken;
            resolved_pc_d     = head.pc;
            resolved_target_d = bru.res_target;
            resolved_state_d  = head.state;
            if (branch_count_q != '1)
                branch_count_d = branch_count_q + 32'd1;
        end

        if (pop && mispredict) begin
            // Everything younger is wrong-path, including a same-cycle push.
            redirect_valid_d = 1'b1;
            redirect_pc_d    = correct_pc;
            rd_ptr_d         = '0;
            wr_ptr_d         = '0;
            count_d          = '0;
            if (mispredict_count_q != '1)
                mispredict_count_d = mispredict_count_q + 32'd1;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{pc:          bru.push_pc,
                                    pred_taken:  bru.push_pred_taken,
                                    pred_target: bru.push_pred_target,
                                    state:       bru.push_state};
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (pop)
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mem_q              <= '{default: '0};
            rd_ptr_q           <= '0;
            wr_ptr_q           <= '0;
            count_q            <= '0;
            update_en_q        <= 1'b0;
            branch_taken_q     <= 1'b0;
            resolved_pc_q      <= '0;
            resolved_target_q  <= '0;
            resolved_state_q   <= '0;
            redirect_valid_q   <= 1'b0;
            redirect_pc_q      <= '0;
            res_error_q        <= 1'b0;
            branch_count_q     <= '0;
            mispredict_count_q <= '0;
        end else begin
            mem_q              <= mem_d;
            rd_ptr_q           <= rd_ptr_d;
            wr_ptr_q           <= wr_ptr_d;
            count_q            <= count_d;
            update_en_q        <= update_en_d;
            branch_taken_q     <= branch_taken_d;
            resolved_pc_q      <= resolved_pc_d;
            resolved_target_q  <= resolved_target_d;
            resolved_state_q   <= resolved_state_d;
            redirect_valid_q   <= redirect_valid_d;
            redirect_pc_q      <= redirect_pc_d;
            res_error_q        <= res_error_d;
            branch_count_q     <= branch_count_d;
            mispredict_count_q <= mispredict_count_d;
        end
    end

    assign bru.push_ready       = push_ready;
    assign bru.update_en        = update_en_q;
    assign bru.branch_taken     = branch_taken_q;
    assign bru.resolved_pc      = resolved_pc_q;
    assign bru.resolved_target  = resolved_target_q;
    assign bru.resolved_state   = resolved_state_q;
    assign bru.redirect_valid   = redirect_valid_q;
    assign bru.redirect_pc      = redirect_pc_q;
    assign bru.res_error        = res_error_q;
    assign bru.branch_count     = branch_count_q;
    assign bru.mispredict_count = mispredict_count_q;
endmodule

// File: tb/tb_branch_resolution_unit.sv
// Directed bench for branch_resolution_unit with a reference prediction queue
// and a scoreboard of expected per-cycle update/redirect results.
module tb_branch_resolution_unit;
    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [31:0] pc;
        logic        pt;
        logic [31:0] tgt;
        logic [1:0]  st;
    } ent_t;

    typedef struct packed {
        logic        update_en;
        logic        branch_taken;
        logic [31:0] pc;
        logic [31:0] target;
        logic [1:0]  state;
        logic        redirect;
        logic [31:0] rpc;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   failures = 0;

    ent_t        model[$];
    exp_t        sb[$];
    logic [31:0] m_br = '0;
    logic [31:0] m_mis = '0;
    logic        m_err = 1'b0;

    branch_resolution_unit_if bru_if ();

    branch_resolution_unit #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bru (bru_if)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        bru_if.push_valid       = 1'b0;
        bru_if.push_pc          = '0;
        bru_if.push_pred_taken  = 1'b0;
        bru_if.push_pred_target = '0;
        bru_if.push_state       = '0;
        bru_if.res_valid        = 1'b0;
        bru_if.res_is_branch    = 1'b0;
        bru_if.res_taken        = 1'b0;
        bru_if.res_target       = '0;
    endtask

    task automatic check_stats();
        chk("res_error", {31'b0, bru_if.res_error}, {31'b0, m_err});
        chk("branch_count", bru_if.branch_count, m_br);
        chk("mispredict_count", bru_if.mispredict_count, m_mis);
    endtask

    // One clock of stimulus: optional push and optional resolve.
    task automatic step(input logic pv, input logic [31:0] pc, input logic pt,
                        input logic [31:0] ptgt, input logic [1:0] pst,
                        input logic rv, input logic isb, input logic tk,
                        input logic [31:0] rtgt);
        ent_t e;
        exp_t x;
        logic acc;
        logic mis;
        x   = '0;
        mis = 1'b0;
        acc = pv && (model.size() < DEPTH);
        chk("push_ready", {31'b0, bru_if.push_ready}, {31'b0, (model.size() < DEPTH)});

        bru_if.push_valid       = pv;
        bru_if.push_pc          = pc;
        bru_if.push_pred_taken  = pt;
        bru_if.push_pred_target = ptgt;
        bru_if.push_state       = pst;
        bru_if.res_valid        = rv;
        bru_if.res_is_branch    = isb;
        bru_if.res_taken        = tk;
        bru_if.res_target       = rtgt;

        if (rv) begin
            if (model.size() == 0) begin
                m_err = 1'b1;
            end else begin
                e = model[0];
                if (isb) begin
                    if (tk != e.pt) mis = 1'b1;
                    if (tk && e.pt && (rtgt != e.tgt)) mis = 1'b1;
                    x.update_en    = 1'b1;
                    x.branch_taken = tk;
                    x.pc           = e.pc;
                    x.target       = rtgt;
                    x.state        = e.st;
                    if (m_br != 32'hFFFF_FFFF) m_br = m_br + 1;
                end else begin
                    mis = e.pt;
                end
                if (mis) begin
                    x.redirect = 1'b1;
                    x.rpc      = (isb && tk) ? rtgt : e.pc + 32'd4;
                    if (m_mis != 32'hFFFF_FFFF) m_mis = m_mis + 1;
                    model.delete();
                    acc = 1'b0;
                end else begin
                    void'(model.pop_front());
                end
            end
        end
        if (acc) model.push_back('{pc: pc, pt: pt, tgt: ptgt, st: pst});
        sb.push_back(x);

        @(posedge clk);
        #1;
        idle_inputs();
        x = sb.pop_front();
        chk("update_en", {31'b0, bru_if.update_en}, {31'b0, x.update_en});
        chk("redirect_valid", {31'b0, bru_if.redirect_valid}, {31'b0, x.redirect});
        if (x.update_en) begin
            chk("branch_taken", {31'b0, bru_if.branch_taken}, {31'b0, x.branch_taken});
            chk("resolved_pc", bru_if.resolved_pc, x.pc);
            chk("resolved_target", bru_if.resolved_target, x.target);
            chk("resolved_state", {30'b0, bru_if.resolved_state}, {30'b0, x.state});
        end
        if (x.redirect)
            chk("redirect_pc", bru_if.redirect_pc, x.rpc);
        check_stats();
    endtask

    task automatic do_push(input logic [31:0] pc, input logic pt,
                           input logic [31:0] ptgt, input logic [1:0] pst);
        step(1'b1, pc, pt, ptgt, pst, 1'b0, 1'b0, 1'b0, '0);
    endtask

    task automatic do_res(input logic isb, input logic tk, input logic [31:0] rtgt);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1, isb, tk, rtgt);
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_push_ready"}, {31'b0, bru_if.push_ready}, 32'd1);
        chk({tag, "_update_en"}, {31'b0, bru_if.update_en}, 32'd0);
        chk({tag, "_branch_taken"}, {31'b0, bru_if.branch_taken}, 32'd0);
        chk({tag, "_resolved_pc"}, bru_if.resolved_pc, 32'd0);
        chk({tag, "_resolved_target"}, bru_if.resolved_target, 32'd0);
        chk({tag, "_resolved_state"}, {30'b0, bru_if.resolved_state}, 32'd0);
        chk({tag, "_redirect_valid"}, {31'b0, bru_if.redirect_valid}, 32'd0);
        chk({tag, "_redirect_pc"}, bru_if.redirect_pc, 32'd0);
        chk({tag, "_res_error"}, {31'b0, bru_if.res_error}, 32'd0);
        chk({tag, "_branch_count"}, bru_if.branch_count, 32'd0);
        chk({tag, "_mispredict_count"}, bru_if.mispredict_count, 32'd0);
    endtask

    initial begin
        idle_inputs();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        rst = 1'b0;

        // Correctly predicted not-taken branch.
        do_push(32'h100, 1'b0, 32'h0, 2'b00);
        do_res(1'b1, 1'b0, 32'h140);

        // Direction right, target wrong.
        do_push(32'h200, 1'b1, 32'h300, 2'b10);
        do_res(1'b1, 1'b1, 32'h380);

        // Mispredict flushes younger entries; next resolve hits an empty queue.
        do_push(32'h10, 1'b0, 32'h0, 2'b01);
        do_push(32'h14, 1'b0, 32'h0, 2'b01);
        do_push(32'h18, 1'b0, 32'h0, 2'b01);
        do_res(1'b1, 1'b1, 32'h40);
        do_res(1'b1, 1'b0, 32'h50);

        // Fill, blocked push alongside pop, then pop alone.
        for (int i = 0; i < DEPTH; i++)
            do_push(32'h1000 + 32'(i) * 4, 1'b0, 32'h0, 2'(i));
        step(1'b1, 32'h2000, 1'b0, 32'h0, 2'b11, 1'b1, 1'b1, 1'b0, 32'h9000);
        do_res(1'b1, 1'b0, 32'h9004);

        // Concurrent push/pop rounds wrap the pointers.
        for (int i = 0; i < 10; i++)
            step(1'b1, 32'h3000 + 32'(i) * 8, 1'b0, 32'h0, 2'(i),
                 1'b1, 1'b1, 1'b0, 32'h7000 + 32'(i));
        do_res(1'b1, 1'b0, 32'h7100);
        do_res(1'b1, 1'b0, 32'h7104);

        // Non-branch that the BTB aliased as taken.
        do_push(32'h500, 1'b1, 32'h600, 2'b11);
        do_res(1'b0, 1'b0, 32'h0);

        // Asynchronous reset with entries queued and a mispredict pending.
        do_push(32'h800, 1'b1, 32'h900, 2'b01);
        do_push(32'h804, 1'b0, 32'h0, 2'b01);
        do_push(32'h808, 1'b0, 32'h0, 2'b01);
        bru_if.res_valid     = 1'b1;
        bru_if.res_is_branch = 1'b1;
        bru_if.res_taken     = 1'b0;
        bru_if.res_target    = 32'h0;
        #2;
        rst = 1'b1;
        #1;
        check_all_zero("async_reset");
        idle_inputs();
        model.delete();
        sb.delete();
        m_br  = '0;
        m_mis = '0;
        m_err = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;

        // Normal operation resumes after reset.
        do_push(32'h40, 1'b1, 32'h80, 2'b10);
        do_res(1'b1, 1'b1, 32'h80);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
